// File: rtl/rect_draw_pkg.sv
// Shared widths, colours, screen defaults and FSM encoding for the rectangle plotter.
package rect_draw_pkg;
  localparam int COORD_W       = 10;
  localparam int COLOUR_W      = 3;
  localparam int DEF_SCREEN_W  = 160;
  localparam int DEF_SCREEN_H  = 120;
  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/rect_scan_counter.sv
// Raster-order cx/cy scan pair; last flags the final pixel (w_last, h_last) of a rectangle.
module rect_scan_counter
  import rect_draw_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] w_last,
  input  logic [COORD_W-1:0] h_last,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               last
);

  assign last = (cx == w_last) && (cy == h_last);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (load) begin
      cx <= '0;
      cy <= '0;
    end else if (advance) begin
      if (cx == w_last) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_draw.sv
// Filled-rectangle plotter: one go pulse becomes a w*h raster of clipped pixel writes.
// state   | meaning
// IDLE    | waiting for go; inputs latched on acceptance
// DRAW    | one pixel per cycle, clipped pixels still take their cycle
// DONE    | single-cycle done pulse, then back to IDLE
module rect_draw
  import rect_draw_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                go,
  input  logic [COORD_W-1:0]  x_in,
  input  logic [COORD_W-1:0]  y_in,
  input  logic [COORD_W-1:0]  w_in,
  input  logic [COORD_W-1:0]  h_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                erase,
  output logic                writeEn,
  output logic [COORD_W-1:0]  x_out,
  output logic [COORD_W-1:0]  y_out,
  output logic [COLOUR_W-1:0] colour,
  output logic                busy,
  output logic                done
);

  localparam logic [COORD_W:0] LIM_X = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] LIM_Y = (COORD_W+1)'(SCREEN_H);

  state_t               state;
  logic [COORD_W-1:0]   x0, y0, w_last, h_last;
  logic [COLOUR_W-1:0]  col_l;
  logic [COORD_W-1:0]   cx, cy;
  logic                 last;
  logic                 accept;
  logic [COORD_W:0]     px, py;

  assign accept = (state == ST_IDLE) && go;
  // One extra bit so positions past 1023 clip instead of wrapping on-screen.
  assign px = {1'b0, x0} + {1'b0, cx};
  assign py = {1'b0, y0} + {1'b0, cy};

  rect_scan_counter u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .load    (accept),
    .advance (state == ST_DRAW),
    .w_last  (w_last),
    .h_last  (h_last),
    .cx      (cx),
    .cy      (cy),
    .last    (last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      writeEn <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      colour  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      x0      <= '0;
      y0      <= '0;
      w_last  <= '0;
      h_last  <= '0;
      col_l   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          writeEn <= 1'b0;
          done    <= 1'b0;
          if (go) begin
            x0     <= x_in;
            y0     <= y_in;
            w_last <= w_in - 1'b1;
            h_last <= h_in - 1'b1;
            col_l  <= erase ? BLACK : colour_in;
            busy   <= 1'b1;
            state  <= (w_in == '0 || h_in == '0) ? ST_DONE : ST_DRAW;
          end
        end
        ST_DRAW: begin
          writeEn <= (px < LIM_X) && (py < LIM_Y);
          x_out   <= px[COORD_W-1:0];
          y_out   <= py[COORD_W-1:0];
          colour  <= col_l;
          if (last) state <= ST_DONE;
        end
        ST_DONE: begin
          writeEn <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_draw.sv
// Self-checking bench for rect_draw: queue-based raster model checked every cycle plus literal pins.
module tb_rect_draw;

  logic       clk = 1'b0;
  logic       resetn;
  logic       go;
  logic [9:0] x_in, y_in, w_in, h_in;
  logic [2:0] colour_in;
  logic       erase;
  logic       writeEn;
  logic [9:0] x_out, y_out;
  logic [2:0] colour;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rect_draw dut (
    .clk       (clk),
    .resetn    (resetn),
    .go        (go),
    .x_in      (x_in),
    .y_in      (y_in),
    .w_in      (w_in),
    .h_in      (h_in),
    .colour_in (colour_in),
    .erase     (erase),
    .writeEn   (writeEn),
    .x_out     (x_out),
    .y_out     (y_out),
    .colour    (colour),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected outputs for each upcoming cycle, built from the rectangle description.
  typedef struct {
    bit       we;
    int       x;
    int       y;
    int       c;
    bit       busy;
    bit       done;
  } rec_t;

  rec_t q[$];
  rec_t exp_r;

  function automatic rec_t mk(bit we, int x, int y, int c, bit b, bit d);
    rec_t r;
    r.we = we; r.x = x; r.y = y; r.c = c; r.busy = b; r.done = d;
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      exp_r = mk(0, 0, 0, 0, 0, 0);
    end else if (q.size() != 0) begin
      exp_r = q.pop_front();
    end else if (go) begin
      int ecol;
      ecol = erase ? 0 : int'(colour_in);
      exp_r = mk(0, 0, 0, 0, 1, 0);
      for (int j = 0; j < int'(h_in); j++)
        for (int i = 0; i < int'(w_in); i++) begin
          int ax, ay;
          ax = int'(x_in) + i;
          ay = int'(y_in) + j;
          q.push_back(mk((ax < 160) && (ay < 120), ax % 1024, ay % 1024, ecol, 1, 0));
        end
      q.push_back(mk(0, 0, 0, 0, 0, 1));
    end else begin
      exp_r = mk(0, 0, 0, 0, 0, 0);
    end
  end

  always @(negedge clk) begin
    chk("writeEn", int'(writeEn), int'(exp_r.we));
    chk("busy", int'(busy), int'(exp_r.busy));
    chk("done", int'(done), int'(exp_r.done));
    if (exp_r.we) begin
      chk("x_out", int'(x_out), exp_r.x);
      chk("y_out", int'(y_out), exp_r.y);
      chk("colour", int'(colour), exp_r.c);
    end
  end

  // Pixel log for literal checks; index 0 is the cycle right after the accepting edge.
  int px_x[$], px_y[$], px_c[$], px_cyc[$];

  task automatic start(input int x, input int y, input int w, input int h,
                       input int c, input bit e);
    x_in = 10'(x); y_in = 10'(y); w_in = 10'(w); h_in = 10'(h);
    colour_in = 3'(c); erase = e; go = 1'b1;
    @(posedge clk);
    #2 go = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int wr);
    px_x.delete(); px_y.delete(); px_c.delete(); px_cyc.delete();
    cyc = -1;
    wr  = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (writeEn) begin
        wr++;
        px_x.push_back(int'(x_out));
        px_y.push_back(int'(y_out));
        px_c.push_back(int'(colour));
        px_cyc.push_back(cyc);
      end
      if (done) break;
      if (cyc > 3000) begin
        chk("done_timeout", cyc, -1);
        break;
      end
    end
    @(posedge clk);
    #2;
  endtask

  int cyc, wr;
  int ex_x[6] = '{10, 11, 12, 10, 11, 12};
  int ex_y[6] = '{20, 20, 20, 21, 21, 21};

  initial begin
    resetn = 1'b0; go = 1'b0; erase = 1'b0;
    x_in = '0; y_in = '0; w_in = '0; h_in = '0; colour_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_writeEn", int'(writeEn), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_x_out", int'(x_out), 0);
    #1 resetn = 1'b1;
    @(posedge clk); #2;

    // Basic fill
    start(10, 20, 3, 2, 5, 0);
    wait_done(cyc, wr);
    chk("basic_done_cycle", cyc, 7);
    chk("basic_writes", wr, 6);
    for (int i = 0; i < 6 && i < wr; i++) begin
      chk("basic_px_x", px_x[i], ex_x[i]);
      chk("basic_px_y", px_y[i], ex_y[i]);
      chk("basic_px_c", px_c[i], 5);
      chk("basic_px_cyc", px_cyc[i], i + 1);
    end
    chk("basic_busy_after", int'(busy), 0);

    // Clipping at the bottom-right corner
    start(158, 119, 4, 2, 2, 0);
    wait_done(cyc, wr);
    chk("clip_done_cycle", cyc, 9);
    chk("clip_writes", wr, 2);
    if (wr == 2) begin
      chk("clip_px0_x", px_x[0], 158);
      chk("clip_px1_x", px_x[1], 159);
      chk("clip_px1_y", px_y[1], 119);
      chk("clip_px1_cyc", px_cyc[1], 2);
    end

    // Zero width
    start(3, 3, 0, 5, 6, 0);
    wait_done(cyc, wr);
    chk("zero_done_cycle", cyc, 1);
    chk("zero_writes", wr, 0);

    // Erase forces black
    start(1, 2, 2, 2, 7, 1);
    wait_done(cyc, wr);
    chk("erase_writes", wr, 4);
    for (int i = 0; i < wr; i++) chk("erase_colour", px_c[i], 0);

    // Far off-screen, crossing the 10-bit boundary: all clipped
    start(1020, 5, 8, 1, 3, 0);
    wait_done(cyc, wr);
    chk("wrap_writes", wr, 0);
    chk("wrap_done_cycle", cyc, 9);

    // Busy protection: go held high, x_in changing every cycle
    x_in = 10'd40; y_in = 10'd30; w_in = 10'd2; h_in = 10'd2;
    colour_in = 3'd4; erase = 1'b0; go = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      #2 x_in = 10'(40 + i * 7);
      @(negedge clk);
      if (i == 2) chk("hold_first_x", int'(x_out), 40);
      if (i == 6) chk("hold_first_done", int'(done), 1);
      @(posedge clk);
    end
    #2 go = 1'b0;
    wait_done(cyc, wr);
    chk("hold_second_done_cycle", cyc, 5);
    chk("hold_second_writes", wr, 4);
    if (wr > 0) chk("hold_second_x", px_x[0], 82);

    // Reset during the third pixel of a 4x4
    start(50, 50, 4, 4, 3, 0);
    repeat (3) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("mid_rst_writeEn", int'(writeEn), 0);
    chk("mid_rst_x_out", int'(x_out), 0);
    chk("mid_rst_y_out", int'(y_out), 0);
    chk("mid_rst_colour", int'(colour), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #2;
    start(50, 50, 4, 4, 3, 0);
    wait_done(cyc, wr);
    chk("post_rst_done_cycle", cyc, 17);
    chk("post_rst_writes", wr, 16);
    if (wr > 0) begin
      chk("post_rst_px0_x", px_x[0], 50);
      chk("post_rst_px0_y", px_y[0], 50);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_draw.md
# rect_draw

Generic filled-rectangle plotter that turns one start pulse plus a rectangle description into a raster stream of pixel writes. It sits directly upstream of `draw_mux`, in the same slot as the ball, brick and platform drawers, and produces `x_out`/`y_out`/`colour`/`writeEn` in exactly the form `draw_mux` forwards to the VGA adapter. Cycle count is fixed at w*h+1, so `draw_fsm` can use constant delays.

## Interface
Parameters:
- SCREEN_W, 160, visible width in pixels; pixels with x ≥ SCREEN_W are clipped.
- SCREEN_H, 120, visible height in pixels; pixels with y ≥ SCREEN_H are clipped.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  reset. Asynchronous and active-low; the only clock is `clk`.
- go  in  1  start request, sampled on the rising edge; honoured only in IDLE.
- x_in  in  10  top-left x.
- y_in  in  10  top-left y.
- w_in  in  10  width in pixels; 0 is legal.
- h_in  in  10  height in pixels; 0 is legal.
- colour_in  in  3  fill colour.
- erase  in  1  when 1, emit BLACK (3'b000) instead of `colour_in`.
- writeEn  out  1  pixel write strobe for `draw_mux`.
- x_out  out  10  pixel x.
- y_out  out  10  pixel y.
- colour  out  3  pixel colour.
- busy  out  1  high while a rectangle is in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE
  - DRAW
  - DONE
- Reset (async, any state): state = IDLE; writeEn, x_out, y_out, colour, busy, done = 0; scan counters cx, cy = 0.
- IDLE: when `go` = 1:
  - Latch x_in, y_in, w_in, h_in, and the effective colour (erase ? BLACK : colour_in).
  - Clear cx and cy.
  - If w = 0 or h = 0, go to DONE; otherwise go to DRAW.
- DRAW, each edge:
  - Register pixel (x0+cx, y0+cy) with its colour.
  - writeEn = 1 only if x0+cx < SCREEN_W and y0+cy < SCREEN_H, compared at 11 bits so there is no 10-bit wrap.
  - x_out and y_out take the low 10 bits of the sum.
  - Advance in raster order: cx increments; when cx = w-1, cx returns to 0 and cy increments.
  - On the edge that emits (w-1, h-1), go to DONE.
- DONE, one edge: writeEn = 0, done = 1, busy = 0, go to IDLE.
- `done` clears on the following edge.
- Clipped pixels still consume their cycle, so the cycle count does not depend on position.
- `go` in DRAW or DONE is ignored and not queued.
- Input changes after the latch edge do not affect the rectangle in progress.
- `colour` holds its last value while writeEn = 0. `draw_mux` gates on writeEn.

## Timing
Let k be the edge where `go` is accepted, and N = w*h.
- busy = 1 from edge k to edge k+N+1.
- Pixel i (0 ≤ i < N) is presented after edge k+1+i. All outputs are registered; there is no combinational path from inputs to outputs.
- done = 1 for exactly the cycle after edge k+N+1.
- Earliest next acceptance of `go` is edge k+N+2, giving a minimum pitch of N+2 cycles.
- N = 0: the FSM goes directly to DONE, done follows edge k+1, and writeEn is never asserted.
- Maximum N is 1023*1023. Counters are 10 bits each; the end-of-rectangle test uses the latched w-1 and h-1.
- Reset asserted mid-rectangle: writeEn drops immediately (asynchronously) and no `done` is produced.

## Structure
- Shared package holds:
  - Coordinate width: 10.
  - Colour width: 3.
  - BLACK = 3'b000.
  - Default screen dimensions 160x120.
  - State encoding constants for IDLE/DRAW/DONE.
- One sub-module is natural: `rect_scan_counter`.
  - Holds the cx/cy pair with load, advance and `last` outputs, for w, h ≥ 1.
  - `rect_draw` owns the FSM, latches, clipping and output registers.

## Test plan
- **Basic fill:** x_in=10, y_in=20, w=3, h=2, colour=3'b101, go pulse at edge k.
  - Writes (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) after edges k+1..k+6.
  - done pulse after k+7; busy low thereafter.
- **Clipping:** x_in=158, y_in=119, w=4, h=2.
  - Exactly 2 writes, (158,119) and (159,119), in cycles 1-2.
  - writeEn = 0 for cycles 3-8.
  - done after edge k+9.
- **Zero size and erase:** w=0, h=5 → done after k+1 with no writes. Separately, erase=1 with colour_in=3'b111 → every write carries colour 3'b000.
- **Busy protection:** `go` held high for the whole rectangle with different x_in values.
  - Only the first rectangle is drawn.
  - The next one starts at edge k+N+2 with newly latched inputs.
- **Reset mid-rectangle:** resetn low during pixel 3 of a 4x4 rectangle.
  - All outputs are 0 without waiting for an edge; done is never seen.
  - After release, a new `go` draws normally from (x0,y0).
